// File: rtl/otf_result_converter.sv
// On-the-fly converter: turns a stream of signed quotient digits {-1,0,+1} into a
// two's-complement result without carry propagation, using the Q / QM register pair.
module otf_result_converter #(
   parameter int DIGITS       = 64,
   parameter int ONLINE_DELAY = 2,
   parameter int CNT_W        = 11
) (
   input  logic              clk,
   input  logic              asyn_reset,
   input  logic              start,
   input  logic [1:0]        digit_in,
   input  logic              digit_valid,
   output logic              digit_ready,
   input  logic              res_ready,
   output logic              res_valid,
   output logic [DIGITS:0]   result,
   output logic [CNT_W-1:0]  digit_cnt,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   // Handshake rule: a digit moves on a rising edge where digit_valid and digit_ready
   // are both 1; a result leaves on an edge where res_valid and res_ready are both 1.

   if (DIGITS + ONLINE_DELAY >= (1 << CNT_W)) begin : g_cnt_check
      $error("otf_result_converter: digit_cnt would wrap; widen CNT_W");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      CONV = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(ONLINE_DELAY);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(ONLINE_DELAY + DIGITS);

   state_t            state, state_nx;
   logic [DIGITS:0]   q_reg, q_nx;
   logic [DIGITS:0]   qm_reg, qm_nx;
   logic [DIGITS:0]   result_nx;
   logic [CNT_W-1:0]  cnt_nx, cnt_inc;
   logic              accept, dig_pos, dig_neg;

   assign digit_ready = (state == FILL) || (state == CONV);
   assign busy        = digit_ready;
   assign res_valid   = (state == HOLD);
   assign state_dbg   = state;

   assign accept  = digit_valid && digit_ready;
   assign cnt_inc = digit_cnt + CNT_W'(1);
   // 2'b11 falls through to the zero-digit case on purpose.
   assign dig_pos = (digit_in == 2'b01);
   assign dig_neg = (digit_in == 2'b10);

   always_comb begin
      state_nx  = state;
      cnt_nx    = digit_cnt;
      q_nx      = q_reg;
      qm_nx     = qm_reg;
      result_nx = result;
      case (state)
         IDLE: begin
            if (start) begin
               cnt_nx   = '0;
               q_nx     = '0;
               qm_nx    = '1;
               state_nx = (ONLINE_DELAY == 0) ? CONV : FILL;
            end
         end
         FILL: begin
            if (accept) begin
               cnt_nx = cnt_inc;
               if (cnt_inc == FILL_LAST) state_nx = CONV;
            end
         end
         CONV: begin
            if (accept) begin
               cnt_nx = cnt_inc;
               if (dig_pos) begin
                  q_nx  = {q_reg[DIGITS-1:0], 1'b1};
                  qm_nx = {q_reg[DIGITS-1:0], 1'b0};
               end else if (dig_neg) begin
                  q_nx  = {qm_reg[DIGITS-1:0], 1'b1};
                  qm_nx = {qm_reg[DIGITS-1:0], 1'b0};
               end else begin
                  q_nx  = {q_reg[DIGITS-1:0], 1'b0};
                  qm_nx = {qm_reg[DIGITS-1:0], 1'b1};
               end
               if (cnt_inc == CONV_LAST) begin
                  state_nx  = HOLD;
                  result_nx = q_nx;
               end
            end
         end
         HOLD: begin
            if (res_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         state     <= IDLE;
         digit_cnt <= '0;
         q_reg     <= '0;
         qm_reg    <= '0;
         result    <= '0;
      end else begin
         state     <= state_nx;
         digit_cnt <= cnt_nx;
         q_reg     <= q_nx;
         qm_reg    <= qm_nx;
         result    <= result_nx;
      end
   end

endmodule

// File: tb/tb_otf_result_converter.sv
// Bench for otf_result_converter with DIGITS=8, ONLINE_DELAY=2: vector table,
// randomized gaps with a reference sum, and an aborted-by-reset conversion.
module tb_otf_result_converter;

   localparam int DIGITS = 8;
   localparam int OD     = 2;
   localparam int CNT_W  = 11;
   localparam int W      = DIGITS + 1;

   logic              clk;
   logic              asyn_reset;
   logic              start;
   logic [1:0]        digit_in;
   logic              digit_valid;
   logic              digit_ready;
   logic              res_ready;
   logic              res_valid;
   logic [W-1:0]      result;
   logic [CNT_W-1:0]  digit_cnt;
   logic              busy;
   logic [1:0]        state_dbg;

   otf_result_converter #(.DIGITS(DIGITS), .ONLINE_DELAY(OD), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .asyn_reset  (asyn_reset),
      .start       (start),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .res_ready   (res_ready),
      .res_valid   (res_valid),
      .result      (result),
      .digit_cnt   (digit_cnt),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      string        name;
      logic [15:0]  digs;
      logic [W-1:0] exp;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sum of q_j * 2^(DIGITS-j), first digit in the top bit pair.
   function automatic logic [W-1:0] ref_val(input logic [15:0] d);
      int s;
      logic [1:0] q;
      s = 0;
      for (int j = 0; j < DIGITS; j++) begin
         q = d[2*(DIGITS-1-j) +: 2];
         if (q == 2'b01) s = s + (1 << (DIGITS-1-j));
         else if (q == 2'b10) s = s - (1 << (DIGITS-1-j));
      end
      return s[W-1:0];
   endfunction

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send_digit(input logic [1:0] d, input int gap);
      int n;
      logic [CNT_W-1:0] cnt0;
      cnt0 = digit_cnt;
      for (int g = 0; g < gap; g++) begin
         digit_valid = 1'b0;
         digit_in    = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
      end
      if (gap > 0) chk("stall_cnt", 32'(digit_cnt), 32'(cnt0));
      digit_valid = 1'b1;
      digit_in    = d;
      n = 0;
      while (!digit_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("digit_ready_timeout", 32'(digit_ready), 1);
      @(posedge clk); #1;
      digit_valid = 1'b0;
      digit_in    = 2'($urandom_range(0, 3));
   endtask

   task automatic run_conv(input logic [15:0] digs, input logic [W-1:0] exp,
                           input int gap_max, input int hold_cycles);
      logic [W-1:0] exp_v, held;
      logic stable;
      exp_q.push_back(exp);
      // digit_valid rides along with start; IDLE must not take the digit.
      start = 1'b1; digit_valid = 1'b1; digit_in = 2'b01;
      @(posedge clk); #1;
      start = 1'b0; digit_valid = 1'b0;
      chk("start_cnt", 32'(digit_cnt), 0);
      chk("start_busy", 32'(busy), 1);
      for (int i = 0; i < OD; i++) send_digit(2'($urandom_range(0, 3)), $urandom_range(0, gap_max));
      chk("fill_cnt", 32'(digit_cnt), OD);
      for (int i = 0; i < DIGITS; i++) send_digit(digs[2*(DIGITS-1-i) +: 2], $urandom_range(0, gap_max));
      chk("res_valid_latency", 32'(res_valid), 1);
      chk("final_cnt", 32'(digit_cnt), OD + DIGITS);
      chk("hold_ready", 32'(digit_ready), 0);
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'(exp_q.size()), 1);
      else begin
         exp_v = exp_q.pop_front();
         chk("result", 32'(result), 32'(exp_v));
      end
      held   = result;
      stable = 1'b1;
      for (int k = 0; k < hold_cycles; k++) begin
         start = (k == hold_cycles / 2);
         @(posedge clk); #1;
         start = 1'b0;
         if (res_valid !== 1'b1 || result !== held) stable = 1'b0;
      end
      chk("hold_stable", 32'(stable), 1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("release_valid", 32'(res_valid), 0);
      chk("release_busy", 32'(busy), 0);
      chk("idle_result", 32'(result), 32'(held));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_result"}, 32'(result), 0);
      chk({tag, "_res_valid"}, 32'(res_valid), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_digit_ready"}, 32'(digit_ready), 0);
      chk({tag, "_digit_cnt"}, 32'(digit_cnt), 0);
      chk({tag, "_state"}, 32'(state_dbg), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      asyn_reset = 1'b1; start = 1'b0; digit_valid = 1'b0; digit_in = 2'b00; res_ready = 1'b0;
      #3;
      chk_all_zero("reset");
      @(posedge clk); #1;
      asyn_reset = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("idle_wait_busy", 32'(busy), 0);

      vecs[0] = '{"all_plus",      16'h5555, 9'h0FF};
      vecs[1] = '{"all_minus",     16'hAAAA, 9'h101};
      vecs[2] = '{"alt_pm",        16'h6666, 9'h055};
      vecs[3] = '{"alt_p_11",      16'h7777, 9'h0AA};
      vecs[4] = '{"all_zero",      16'h0000, 9'h000};
      vecs[5] = '{"minus_then_p",  16'h9555, 9'h1FF};
      vecs[6] = '{"msb_only",      16'h4000, 9'h080};
      vecs[7] = '{"lsb_minus",     16'h0002, 9'h1FF};
      for (int i = 0; i < 8; i++) run_conv(vecs[i].digs, vecs[i].exp, 0, 2);

      for (int i = 0; i < 4; i++) begin
         rd = 16'($urandom);
         run_conv(rd, ref_val(rd), 3, (i == 0) ? 20 : 3);
      end

      // Abort after the 5th converted digit, then convert zeros.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < OD; i++) send_digit(2'b01, 0);
      for (int i = 0; i < 5; i++) send_digit(2'b01, 0);
      chk("pre_abort_cnt", 32'(digit_cnt), OD + 5);
      asyn_reset = 1'b1;
      #2;
      chk_all_zero("abort");
      @(posedge clk); #1;
      asyn_reset = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle_valid", 32'(res_valid), 0);
      run_conv(16'h0000, 9'h000, 1, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
